fp_round_pack: RTL and testbench
================================

// Module: fp_round_pack
// PURPOSE
//  Final pipeline section of the FP multiplier; the inverse of operand unpacking.
//  Takes the sign, the biased exponent sum, the raw (MANT+1)x(MANT+1) mantissa product and
//  both operands' special-case codes, then normalises, rounds (RNE) and packs a DW-bit result.
//  Two-stage pipeline with valid/ready handshake; sits between the mantissa multiplier and the core output.
// PARAMETERS
//  DW    16  total result width (sign + EXP + MANT)
//  EXP   5   exponent field width; BIAS = 2**(EXP-1)-1
//  MANT  10  stored fraction width; product input is 2*MANT+2 bits
// PORTS
//  clk          in   1          system clock, all flops on rising edge
//  rst_n        in   1          asynchronous active-low reset
//  in_valid     in   1          input beat valid
//  in_ready     out  1          block can accept a beat this cycle
//  sign_in      in   1          result sign (XOR of operand signs)
//  exp_sum      in   EXP+2      signed ea+eb-BIAS; denormal operands already carry exponent 1
//  mant_prod    in   2*MANT+2   unsigned product; binary point between bits 2*MANT and 2*MANT-1
//  spe_case_a   in   3          0 normal, 1 denormal, 2 zero, 3 inf, 4 NaN
//  spe_case_b   in   3          same encoding for operand B
//  out_valid    out  1          result beat valid
//  out_ready    in   1          downstream accepts result
//  result       out  DW         packed IEEE-754 result
//  flags        out  4          {invalid, overflow, underflow, inexact} for this result
// BEHAVIOUR
//  Reset: both stage valids, out_valid, result and flags clear to 0 asynchronously; in_ready=1 after reset.
//  Handshake: beat transfers when valid&&ready at a clk edge. s2_load = !s2_v || out_ready;
//   s1_load = !s1_v || s2_load; in_ready = s1_load (combinational). No bubbles at full throughput.
//   Latency 2 cycles with out_ready=1. result/flags held stable while out_valid && !out_ready.
//  Stage 1 (normalise): if mant_prod[2*MANT+1]: shift right 1 (shifted-out bit to sticky), exp+1.
//   Else left-shift by leading-zero count to set bit 2*MANT, exp-lzc. Zero product forces the zero path.
//   Internal exponent is EXP+3 bits signed; never wraps.
//  Stage 2 (round/pack): if exp<=0: right-shift by 1-exp (shift saturated at MANT+2, all lost bits
//   -> sticky), exp field=0. RNE on guard/round/sticky; add round increment to {exp_field,frac}
//   so a fraction carry bumps the exponent (subnormal->min normal, 1.11..1->next binade).
//   Final exp >= 2**EXP-1 -> +/-inf, overflow=1, inexact=1.
//  inexact = any nonzero guard/round/sticky. underflow = result tiny (pre-round exp<=0) AND inexact.
//  Special cases (override arithmetic, decided in stage 1, all flags 0 except noted):
//   either NaN, or inf x zero -> canonical qNaN {1'b0, all-ones exp, 1'b1, zeros}; invalid=1 only for inf x zero.
//   inf x (normal|denormal|inf) -> {sign_in, all-ones, 0}. zero x (normal|denormal|zero) -> {sign_in, 0}.
//  Simultaneous load and drain in one cycle is legal at every stage. Reset mid-operation discards all
//   in-flight beats; no result produced for them.
// TESTING
//  1.0x1.0: sign 0, exp_sum 15, mant_prod 0x100000 -> 0x3C00, flags 0, out_valid 2 cycles after accept.
//  1.5x1.5: exp_sum 15, mant_prod 0x240000 -> 0x4080 (2.25), flags 0.
//  0x7BFF x 0x7BFF: exp_sum 45, mant_prod 0x3FF001 -> 0x7C00, flags 4'b0101.
//  0x0401 x 0x3800: exp_sum 0, mant_prod 0x100400 -> tie to even 0x0200, flags 4'b0011.
//  spe_case_a=3, spe_case_b=2 -> 0x7E00, flags 4'b1000; spe_case_a=4 -> 0x7E00, flags 0.
//  out_ready=0 for 4 cycles, in_valid=1 -> exactly 2 beats accepted, in_ready low, result stable;
//   release -> results in order, back-to-back; assert rst_n low mid-stream -> out_valid 0 immediately.

Source files
------------

// File: rtl/fp_round_pack.sv
// fp_round_pack: final section of the FP multiplier.
// Normalises the raw mantissa product, rounds to nearest-even, resolves the special
// operand cases and packs the IEEE-754 result. Two pipeline stages with a
// valid/ready handshake; both stages can load and drain in the same cycle.
module fp_round_pack #(
  parameter int DW   = 16,
  parameter int EXP  = 5,
  parameter int MANT = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sign_in,
  input  logic [EXP+1:0]      exp_sum,
  input  logic [2*MANT+1:0]   mant_prod,
  input  logic [2:0]          spe_case_a,
  input  logic [2:0]          spe_case_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       result,
  output logic [3:0]          flags
);

  localparam int PW = 2*MANT+2;          // product width
  localparam int EW = EXP+3;             // internal signed exponent width
  localparam int LW = $clog2(PW+1);      // leading-zero count width
  localparam int SW = $clog2(MANT+3);    // denormalising shift width
  localparam int XW = 3*MANT+3;          // normalised mantissa plus shift-out room
  localparam int GW = EW+MANT;           // {exponent, fraction} rounding adder width

  localparam logic [2:0] SPE_ZERO = 3'd2;
  localparam logic [2:0] SPE_INF  = 3'd3;
  localparam logic [2:0] SPE_NAN  = 3'd4;

  localparam logic [DW-1:0] QNAN = {1'b0, {EXP{1'b1}}, 1'b1, {(MANT-1){1'b0}}};

  localparam logic signed [EW-1:0] ZERO_E  = '0;
  localparam logic signed [EW-1:0] ONE_E   = EW'(1);
  localparam logic signed [EW-1:0] SAT_E   = EW'(-(MANT+1));
  localparam logic        [EW-1:0] EMAX    = EW'(2**EXP-1);

  // handshake
  logic s1_v;
  logic s1_load;
  logic s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_v || s2_load;
  assign in_ready = s1_load;

  // ---------------- stage 1: normalise ----------------
  logic [LW-1:0]          lzc;
  logic                   lz_found;
  logic signed [EW-1:0]   exp_ext;
  logic signed [EW-1:0]   n_exp;
  logic [2*MANT:0]        n_mant;
  logic                   n_sticky;
  logic                   n_spec;
  logic [DW-1:0]          n_spec_res;
  logic [3:0]             n_spec_flags;

  // leading zeros counted from the integer bit position downwards
  always_comb begin
    lzc      = '0;
    lz_found = 1'b0;
    for (int unsigned i = 0; i <= 2*MANT; i++) begin
      if (!lz_found) begin
        if (mant_prod[2*MANT-i]) lz_found = 1'b1;
        else                     lzc      = lzc + LW'(1);
      end
    end
  end

  // bring the leading one to bit 2*MANT and adjust the exponent to match
  always_comb begin
    exp_ext  = {exp_sum[EXP+1], exp_sum};
    n_sticky = 1'b0;
    if (mant_prod[PW-1]) begin
      n_mant   = mant_prod[PW-1:1];
      n_sticky = mant_prod[0];
      n_exp    = exp_ext + ONE_E;
    end else begin
      n_mant   = mant_prod[2*MANT:0] << lzc;
      n_exp    = exp_ext - EW'(lzc);
    end
  end

  // special operand cases and exact-zero products bypass the arithmetic path
  always_comb begin
    n_spec       = 1'b0;
    n_spec_res   = '0;
    n_spec_flags = '0;
    if (spe_case_a == SPE_NAN || spe_case_b == SPE_NAN) begin
      n_spec     = 1'b1;
      n_spec_res = QNAN;
    end else if ((spe_case_a == SPE_INF && spe_case_b == SPE_ZERO) ||
                 (spe_case_a == SPE_ZERO && spe_case_b == SPE_INF)) begin
      n_spec       = 1'b1;
      n_spec_res   = QNAN;
      n_spec_flags = 4'b1000;
    end else if (spe_case_a == SPE_INF || spe_case_b == SPE_INF) begin
      n_spec     = 1'b1;
      n_spec_res = {sign_in, {EXP{1'b1}}, {MANT{1'b0}}};
    end else if (spe_case_a == SPE_ZERO || spe_case_b == SPE_ZERO || mant_prod == '0) begin
      n_spec     = 1'b1;
      n_spec_res = {sign_in, {(DW-1){1'b0}}};
    end
  end

  logic                 s1_sign;
  logic signed [EW-1:0] s1_exp;
  logic [2*MANT:0]      s1_mant;
  logic                 s1_sticky;
  logic                 s1_spec;
  logic [DW-1:0]        s1_spec_res;
  logic [3:0]           s1_spec_flags;

  // stage 1 register: accepts a new beat whenever stage 2 can take the current one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v          <= 1'b0;
      s1_sign       <= 1'b0;
      s1_exp        <= '0;
      s1_mant       <= '0;
      s1_sticky     <= 1'b0;
      s1_spec       <= 1'b0;
      s1_spec_res   <= '0;
      s1_spec_flags <= '0;
    end else if (s1_load) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_sign       <= sign_in;
        s1_exp        <= n_exp;
        s1_mant       <= n_mant;
        s1_sticky     <= n_sticky;
        s1_spec       <= n_spec;
        s1_spec_res   <= n_spec_res;
        s1_spec_flags <= n_spec_flags;
      end
    end
  end

  // ---------------- stage 2: round and pack ----------------
  logic              tiny;
  logic [SW-1:0]     shamt;
  logic [XW-1:0]     ext;
  logic [2*MANT:0]   mant_sh;
  logic              lost;
  logic              guard;
  logic              rnd;
  logic              stk;
  logic              inexact;
  logic              inc;
  logic [EW-1:0]     base;
  logic [GW-1:0]     sum;
  logic [EW-1:0]     fexp;
  logic [DW-1:0]     r_res;
  logic [3:0]        r_flags;

  // Denormalise tiny results, then add the rounding increment to the packed
  // {exponent-1, 1.fraction} so that a fraction carry ripples into the exponent.
  always_comb begin
    tiny  = (s1_exp <= ZERO_E);
    shamt = '0;
    if (tiny) begin
      if (s1_exp <= SAT_E) shamt = SW'(MANT+2);
      else                 shamt = SW'(ONE_E - s1_exp);
    end
    ext     = {s1_mant, {(MANT+2){1'b0}}} >> shamt;
    mant_sh = ext[XW-1:MANT+2];
    lost    = |ext[MANT+1:0];
    guard   = mant_sh[MANT-1];
    rnd     = mant_sh[MANT-2];
    stk     = (|mant_sh[MANT-3:0]) | lost | s1_sticky;
    inexact = guard | rnd | stk;
    inc     = guard & (rnd | stk | mant_sh[MANT]);
    base    = tiny ? '0 : EW'(s1_exp - ONE_E);
    sum     = {base, {MANT{1'b0}}} + GW'(mant_sh[2*MANT:MANT]) + GW'(inc);
    fexp    = sum[GW-1:MANT];
    if (s1_spec) begin
      r_res   = s1_spec_res;
      r_flags = s1_spec_flags;
    end else if (fexp >= EMAX) begin
      r_res   = {s1_sign, {EXP{1'b1}}, {MANT{1'b0}}};
      r_flags = 4'b0101;
    end else begin
      r_res   = {s1_sign, sum[EXP+MANT-1:0]};
      r_flags = {1'b0, 1'b0, tiny & inexact, inexact};
    end
  end

  // output register: holds the result while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (s2_load) begin
      out_valid <= s1_v;
      if (s1_v) begin
        result <= r_res;
        flags  <= r_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pack.sv
// tb_fp_round_pack: directed vectors into a scoreboard queue; a monitor process
// pops and compares every delivered beat.
module tb_fp_round_pack;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [6:0]  exp_sum;
  logic [21:0] mant_prod;
  logic [2:0]  spe_case_a;
  logic [2:0]  spe_case_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  fp_round_pack #(.DW(16), .EXP(5), .MANT(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sign_in    (sign_in),
    .exp_sum    (exp_sum),
    .mant_prod  (mant_prod),
    .spe_case_a (spe_case_a),
    .spe_case_b (spe_case_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flags      (flags)
  );

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  fl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // monitor: a beat is delivered at the next rising edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat actual result=%h flags=%b required none", result, flags);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (result !== e.res || flags !== e.fl) begin
          errors++;
          $display("FAIL beat actual result=%h flags=%b required result=%h flags=%b",
                   result, flags, e.res, e.fl);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic drive(input logic s, input logic [6:0] e, input logic [21:0] p,
                       input logic [2:0] a, input logic [2:0] b);
    in_valid   = 1'b1;
    sign_in    = s;
    exp_sum    = e;
    mant_prod  = p;
    spe_case_a = a;
    spe_case_b = b;
  endtask

  // entered 1 time unit after a rising edge; returns likewise after the accepting edge
  task automatic send(input logic s, input logic [6:0] e, input logic [21:0] p,
                      input logic [2:0] a, input logic [2:0] b,
                      input logic [15:0] res, input logic [3:0] fl);
    int n;
    drive(s, e, p, a, b);
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual in_ready=0 required 1");
    end else begin
      exp_q.push_back('{res, fl});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  logic [6:0]  st_exp [4] = '{7'h0F, 7'h0F, 7'h0F, 7'h14};
  logic [21:0] st_prod[4] = '{22'h100000, 22'h240000, 22'h1FFE00, 22'h040000};
  logic [15:0] st_res [4] = '{16'h3C00, 16'h4080, 16'h4000, 16'h4800};
  logic [3:0]  st_fl  [4] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000};

  initial begin
    int idx;
    int acc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 3'd0, 3'd0);
    in_valid  = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 16'h0000);
    chk("rst_flags", flags, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // latency: result visible two cycles after the accepting cycle
    send(1'b0, 7'h0F, 22'h100000, 3'd0, 3'd0, 16'h3C00, 4'b0000);
    chk("latency_cycle1", out_valid, 0);
    @(posedge clk); #1;
    chk("latency_cycle2", out_valid, 1);

    send(1'b0, 7'h0F, 22'h240000, 3'd0, 3'd0, 16'h4080, 4'b0000); // 1.5*1.5
    send(1'b0, 7'h2D, 22'h3FF001, 3'd0, 3'd0, 16'h7C00, 4'b0101); // max*max overflow
    send(1'b0, 7'h00, 22'h100400, 3'd1, 3'd0, 16'h0200, 4'b0011); // subnormal tie to even
    send(1'b0, 7'h00, 22'h000000, 3'd3, 3'd2, 16'h7E00, 4'b1000); // inf*zero
    send(1'b0, 7'h0F, 22'h100000, 3'd4, 3'd0, 16'h7E00, 4'b0000); // NaN
    send(1'b1, 7'h0F, 22'h100000, 3'd3, 3'd4, 16'h7E00, 4'b0000); // inf*NaN
    send(1'b1, 7'h0F, 22'h100000, 3'd3, 3'd0, 16'hFC00, 4'b0000); // -inf
    send(1'b1, 7'h0F, 22'h000000, 3'd2, 3'd1, 16'h8000, 4'b0000); // -zero
    send(1'b0, 7'h0F, 22'h000000, 3'd0, 3'd0, 16'h0000, 4'b0000); // zero product
    send(1'b0, 7'h0F, 22'h100801, 3'd0, 3'd0, 16'h3C02, 4'b0001); // sticky only
    send(1'b0, 7'h0F, 22'h1FFE00, 3'd0, 3'd0, 16'h4000, 4'b0001); // carry to next binade
    send(1'b0, 7'h00, 22'h1FFC00, 3'd0, 3'd0, 16'h0400, 4'b0011); // subnormal -> min normal
    send(1'b0, 7'h14, 22'h040000, 3'd1, 3'd0, 16'h4800, 4'b0000); // lzc normalise
    send(1'b0, 7'h62, 22'h100000, 3'd0, 3'd0, 16'h0000, 4'b0011); // deep underflow
    send(1'b0, 7'h1E, 22'h1FFC00, 3'd0, 3'd0, 16'h7BFF, 4'b0000); // max normal exact
    send(1'b0, 7'h1E, 22'h1FFE00, 3'd0, 3'd0, 16'h7C00, 4'b0101); // round into overflow
    drain();

    // backpressure: four cycles stalled while offering beats
    out_ready = 1'b0;
    idx = 0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, st_exp[idx], st_prod[idx], 3'd0, 3'd0);
      #1;
      if (in_ready) begin
        exp_q.push_back('{st_res[idx], st_fl[idx]});
        idx++;
        acc++;
      end
      if (c >= 2) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_result", result, 16'h3C00);
      end
      @(posedge clk); #1;
    end
    chk("stall_accepted", acc, 2);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b0;
      if (idx < 4) begin
        drive(1'b0, st_exp[idx], st_prod[idx], 3'd0, 3'd0);
        #1;
        if (in_ready) begin
          exp_q.push_back('{st_res[idx], st_fl[idx]});
          idx++;
        end
      end else begin
        #1;
      end
      chk("release_back_to_back", out_valid, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("release_all_sent", idx, 4);
    drain();

    // reset mid-stream discards in-flight beats
    out_ready = 1'b0;
    drive(1'b0, 7'h0F, 22'h240000, 3'd0, 3'd0);
    @(posedge clk); #1;
    drive(1'b0, 7'h0F, 22'h100000, 3'd0, 3'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_reset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 16'h0000);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(1'b1, 7'h0F, 22'h240000, 3'd0, 3'd0, 16'hC080, 4'b0000);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("idle_out_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
